// File: rtl/transient_holdoff_scheduler_if.sv
// transient_holdoff_scheduler_if: sense/config inputs and holdoff status outputs of the scheduler
interface transient_holdoff_scheduler_if #(parameter int NCH = 8);
  logic                   ena;
  logic [NCH-1:0]         sense_in;
  logic [3:0]             delay_sel;
  logic                   clear_pending;
  logic                   active_valid;
  logic [$clog2(NCH)-1:0] active_ch;
  logic [NCH-1:0]         active_mask;
  logic [NCH-1:0]         pending;
  logic                   overrun;
  modport master (
    output ena, sense_in, delay_sel, clear_pending,
    input  active_valid, active_ch, active_mask, pending, overrun
  );
  modport slave (
    input  ena, sense_in, delay_sel, clear_pending,
    output active_valid, active_ch, active_mask, pending, overrun
  );
endinterface

// File: rtl/transient_holdoff_scheduler.sv
// transient_holdoff_scheduler: round-robin sharing of one holdoff down-counter among NCH sensed lines
module transient_holdoff_scheduler #(
  parameter int NCH  = 8,
  parameter int STEP = 10000,
  parameter int CW   = 18
) (
  input logic clk,
  input logic reset,
  transient_holdoff_scheduler_if.slave bus
);
  localparam int AW = $clog2(NCH);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   last_q, last_d;
  logic [AW-1:0]   ch_q, ch_d;
  logic            valid_q, valid_d;
  logic [NCH-1:0]  pend_q, pend_d;
  logic            ovr_q, ovr_d;
  logic [NCH-1:0]  sense_q;
  logic            primed_q;
  logic [NCH-1:0]  chg;
  logic [NCH-1:0]  grant_mask;
  logic [AW-1:0]   grant_idx;
  logic            grant_hit;
  assign chg = (primed_q && bus.ena) ? (bus.sense_in ^ sense_q) : '0;
  // Round-robin pick: first pending channel strictly after the last one served, wrapping
  always_comb begin
    logic [AW-1:0] k;
    grant_idx = '0;
    grant_hit = 1'b0;
    k = '0;
    for (int i = 1; i <= NCH; i++) begin
      k = last_q + AW'(i);
      if (!grant_hit && pend_q[k]) begin
        grant_hit = 1'b1;
        grant_idx = k;
      end
    end
  end
  // State register; the first cycle after reset only primes the edge detector
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= AW'(NCH - 1);
      ch_q     <= '0;
      valid_q  <= 1'b0;
      pend_q   <= '0;
      ovr_q    <= 1'b0;
      sense_q  <= '0;
      primed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      ch_q     <= ch_d;
      valid_q  <= valid_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
      sense_q  <= bus.sense_in;
      primed_q <= 1'b1;
    end
  end
  // Next state: grant from IDLE loads the timer; HOLD counts down to 0 inclusive, then releases
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    ch_d       = ch_q;
    valid_d    = valid_q;
    grant_mask = '0;
    if (state_q == IDLE) begin
      if (grant_hit) begin
        state_d    = HOLD;
        ch_d       = grant_idx;
        valid_d    = 1'b1;
        cnt_d      = CW'(bus.delay_sel) * CW'(STEP);
        grant_mask = NCH'(1) << grant_idx;
      end
    end else if (cnt_q == '0) begin
      state_d = IDLE;
      valid_d = 1'b0;
      last_d  = ch_q;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
    pend_d = bus.clear_pending ? '0 : ((pend_q & ~grant_mask) | chg);
    ovr_d  = bus.clear_pending ? 1'b0 : (ovr_q | (|(chg & pend_q)));
  end
  // Outputs straight from registers; mask is gated by valid
  always_comb begin
    bus.active_valid = valid_q;
    bus.active_ch    = ch_q;
    bus.active_mask  = valid_q ? (NCH'(1) << ch_q) : '0;
    bus.pending      = pend_q;
    bus.overrun      = ovr_q;
  end
endmodule

// File: tb/tb_transient_holdoff_scheduler.sv
// tb_transient_holdoff_scheduler: directed vector table plus hand sequences for long holds and mid-hold reset
module tb_transient_holdoff_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  transient_holdoff_scheduler_if #(.NCH(8)) bus ();
  transient_holdoff_scheduler #(.NCH(8), .STEP(4), .CW(18)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic       rst;
    logic       ena;
    logic [7:0] sense;
    logic [3:0] dsel;
    logic       clr;
    logic       ev;
    logic [2:0] ech;
    logic [7:0] epend;
    logic       eov;
  } vec_t;
  vec_t vq[$];
  task automatic add(input logic rst, input logic ena, input logic [7:0] sense, input logic [3:0] dsel,
                     input logic clr, input logic ev, input logic [2:0] ech, input logic [7:0] epend,
                     input logic eov);
    vec_t v;
    v.rst = rst; v.ena = ena; v.sense = sense; v.dsel = dsel; v.clr = clr;
    v.ev = ev; v.ech = ech; v.epend = epend; v.eov = eov;
    vq.push_back(v);
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int cnt;
    string tag;
    bus.ena = 1'b1;
    bus.sense_in = 8'hFF;
    bus.delay_sel = 4'd0;
    bus.clear_pending = 1'b0;
    add(1,1,8'hFF,0,0, 0,0,8'h00,0);
    add(1,1,8'hFF,0,0, 0,0,8'h00,0);
    add(0,1,8'hFF,0,0, 0,0,8'h00,0);
    add(0,1,8'hFF,0,0, 0,0,8'h00,0);
    add(0,1,8'hFF,0,0, 0,0,8'h00,0);
    add(0,1,8'h5E,0,0, 0,0,8'hA1,0);
    add(0,1,8'h5E,0,0, 1,0,8'hA0,0);
    add(0,1,8'h5E,0,0, 0,0,8'hA0,0);
    add(0,1,8'h5E,0,0, 1,5,8'h80,0);
    add(0,1,8'h5E,0,0, 0,0,8'h80,0);
    add(0,1,8'h5E,0,0, 1,7,8'h00,0);
    add(0,1,8'h5E,0,0, 0,0,8'h00,0);
    add(0,1,8'h7F,1,0, 0,0,8'h21,0);
    add(0,1,8'h7F,1,0, 1,0,8'h20,0);
    add(0,1,8'h5F,1,0, 1,0,8'h20,1);
    add(0,1,8'h5F,1,0, 1,0,8'h20,1);
    add(0,1,8'h5F,1,1, 1,0,8'h00,0);
    add(0,1,8'h5F,1,0, 1,0,8'h00,0);
    add(0,1,8'h5F,1,0, 0,0,8'h00,0);
    add(0,1,8'h5F,1,0, 0,0,8'h00,0);
    add(0,1,8'h57,1,0, 0,0,8'h08,0);
    add(0,1,8'h57,1,0, 1,3,8'h00,0);
    add(0,1,8'h5F,3,0, 1,3,8'h08,0);
    add(0,1,8'h5F,3,0, 1,3,8'h08,0);
    add(0,1,8'h5F,3,0, 1,3,8'h08,0);
    add(0,1,8'h5F,3,0, 1,3,8'h08,0);
    add(0,1,8'h5F,3,0, 0,0,8'h08,0);
    add(0,1,8'h5F,0,0, 1,3,8'h00,0);
    add(0,1,8'h5F,0,0, 0,0,8'h00,0);
    add(0,0,8'h59,0,0, 0,0,8'h00,0);
    add(0,0,8'h59,0,0, 0,0,8'h00,0);
    add(0,1,8'h59,0,0, 0,0,8'h00,0);
    foreach (vq[i]) begin
      reset = vq[i].rst;
      bus.ena = vq[i].ena;
      bus.sense_in = vq[i].sense;
      bus.delay_sel = vq[i].dsel;
      bus.clear_pending = vq[i].clr;
      step();
      tag = $sformatf("vec%0d", i);
      chk({tag, ".valid"}, 32'(bus.active_valid), 32'(vq[i].ev));
      chk({tag, ".mask"}, 32'(bus.active_mask), vq[i].ev ? (32'd1 << vq[i].ech) : 32'd0);
      chk({tag, ".pending"}, 32'(bus.pending), 32'(vq[i].epend));
      chk({tag, ".overrun"}, 32'(bus.overrun), 32'(vq[i].eov));
      if (vq[i].ev || vq[i].rst) chk({tag, ".ch"}, 32'(bus.active_ch), 32'(vq[i].ech));
    end
    bus.clear_pending = 1'b0;
    bus.sense_in = 8'h5D;
    bus.delay_sel = 4'd3;
    step();
    chk("long.pending", 32'(bus.pending), 32'h04);
    chk("long.prevalid", 32'(bus.active_valid), 32'd0);
    step();
    chk("long.ch", 32'(bus.active_ch), 32'd2);
    chk("long.mask", 32'(bus.active_mask), 32'h04);
    cnt = 0;
    while (bus.active_valid && cnt < 40) begin
      cnt++;
      step();
    end
    chk("long.length", 32'(cnt), 32'd13);
    chk("long.overrun", 32'(bus.overrun), 32'd0);
    step();
    chk("long.idle", 32'(bus.active_valid), 32'd0);
    bus.sense_in = 8'h59;
    bus.delay_sel = 4'd6;
    step();
    chk("rst.pending", 32'(bus.pending), 32'h04);
    step();
    chk("rst.granted", 32'(bus.active_valid), 32'd1);
    repeat (4) step();
    chk("rst.counter", 32'(dut.cnt_q), 32'd20);
    chk("rst.midhold", 32'(bus.active_valid), 32'd1);
    reset = 1'b1;
    bus.sense_in = 8'h5D;
    step();
    chk("rst.valid", 32'(bus.active_valid), 32'd0);
    chk("rst.pend", 32'(bus.pending), 32'd0);
    chk("rst.mask", 32'(bus.active_mask), 32'd0);
    reset = 1'b0;
    step();
    chk("prime.pend", 32'(bus.pending), 32'd0);
    chk("prime.valid", 32'(bus.active_valid), 32'd0);
    step();
    chk("prime.after", 32'(bus.pending), 32'd0);
    bus.sense_in = 8'h5C;
    step();
    chk("post.pending", 32'(bus.pending), 32'h01);
    step();
    chk("post.valid", 32'(bus.active_valid), 32'd1);
    chk("post.ch", 32'(bus.active_ch), 32'd0);
    chk("post.mask", 32'(bus.active_mask), 32'h01);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/transient_holdoff_scheduler.md
Name: transient_holdoff_scheduler

Overview:
- Multi-channel controller that shares one holdoff down-counter among NCH sensed state lines.
- Each edge on a line queues a holdoff request. A round-robin scheduler grants the shared timer to one pending channel at a time and flags it as "in transient" for delay_sel*STEP+1 cycles.
- Sits between raw ui_in-style state inputs and LED/output indication logic; replaces per-channel counters so one timer serves all lines.

Parameters:
- NCH, 8, number of sensed channels (power of 2, 2..8)
- STEP, 10000, clock ticks per delay_sel unit
- CW, 18, holdoff counter width; must satisfy 2^CW > 15*STEP

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- ena  in  1  event capture enable; 0 = ignore input changes
- sense_in  in  NCH  raw state lines (already synchronous to clk)
- delay_sel  in  4  holdoff length in STEP units, sampled at grant
- clear_pending  in  1  single-cycle pulse: clears pending and overrun
- active_valid  out  1  a channel is currently in holdoff
- active_ch  out  clog2(NCH)  index of channel in holdoff
- active_mask  out  NCH  one-hot of active_ch when active_valid, else 0
- pending  out  NCH  queued requests not yet granted
- overrun  out  1  sticky: change seen on an already-pending channel

Behaviour:
- Reset values: active_valid=0, active_ch=0, active_mask=0, pending=0, overrun=0, counter=0, last_grant=NCH-1, state=IDLE, sense_q=0, primed=0.
- Priming: the first non-reset cycle loads sense_q<=sense_in, sets primed=1 and generates no events. After that, sense_q<=sense_in every cycle.
- Event: chg = (sense_in ^ sense_q) when primed && ena, else 0.
- Pending update each cycle, in this order: clear by grant, then set by chg, then clear_pending wins over everything.
  - A chg on a channel being granted that same cycle leaves its pending bit set (re-queued).
- overrun is set when (chg & pending) != 0 in a cycle without clear_pending. It is cleared only by clear_pending or reset.
- A chg on the currently active channel sets its pending bit; it does not restart or extend the current hold.
- FSM states: IDLE, HOLD.
  - IDLE: if pending != 0, grant the first pending channel searching upward from last_grant+1 with wrap.
    - On grant: active_ch<=g, active_valid<=1, counter<=delay_sel*STEP (computed at CW bits, no truncation), clear pending[g], go to HOLD.
    - If pending == 0, stay in IDLE.
  - HOLD: if counter==0, active_valid<=0, last_grant<=active_ch, go to IDLE; else counter<=counter-1.
- Timing:
  - active_valid is high for exactly delay_sel*STEP+1 cycles per grant.
  - After a hold ends there is at least 1 idle cycle (active_valid low) before the next grant.
  - Latency: sense_in changes before edge N → pending set after edge N → grant after edge N+1, so active_valid is visible in cycle N+2.
- delay_sel changes during HOLD are ignored. ena=0 blocks new events only; an in-progress hold and queued grants continue.
- clear_pending during HOLD does not abort the active hold.
- Reset mid-hold: all state returns to reset values on the next edge and the priming cycle repeats.

Test Plan:
- NCH=8, STEP=4. Reset with sense_in=8'hFF, then hold it steady → no pending, active_valid stays 0 (priming suppresses the spurious event).
- delay_sel=3, toggle bit 2 once → pending=8'h04 for 1 cycle, then active_ch=2, active_mask=8'h04, active_valid high for 13 cycles, then low; overrun=0.
- Toggle bits 0, 5 and 7 in the same cycle with last_grant=7, delay_sel=0 → grants in order 0, 5, 7, each active for 1 cycle with 1 idle cycle between grants.
- While channel 5 is pending (not yet granted), toggle bit 5 again → overrun=1 and stays 1. A clear_pending pulse → overrun=0 and pending=0; the current hold is unaffected.
- During a hold on channel 3, toggle bit 3 → hold length unchanged; channel 3 is re-granted after 1 idle cycle. With ena=0, toggle bits → pending remains 0.
- Assert reset mid-hold with counter at 20 → next cycle active_valid=0, pending=0; the following cycle is priming with no events.
